csa_multibyte_scheduler: RTL

- Time-shares one external 8-bit carry-select adder (CarrySelectAdder) between two requesters.
- Each request is a multi-byte add, executed LSB byte first over BYTES cycles, with the carry chained through a register.
- Round-robin arbitration and a req/ack handshake per requester.
- Sits between the two requesters and the single adder instance; the adder itself is instantiated at the parent level.

---
 rtl/csa_multibyte_scheduler_if.sv | 53 +++++
 rtl/csa_multibyte_scheduler.sv | 160 ++++++++++++++++
 2 files changed

// File: rtl/csa_multibyte_scheduler_if.sv
`default_nettype none
// ============================================================================
// Module   : csa_multibyte_scheduler_if
// Brief    : Requester and adder-side signal bundle for csa_multibyte_scheduler.
//            The master side is the parent: it owns both requesters and the
//            single external 8-bit adder. The slave side is the scheduler.
// Revision : 1.0 - initial release
// ============================================================================
interface csa_multibyte_scheduler_if #(
  parameter int BYTES = 4
);
  localparam int c_w = 8 * BYTES;

  // requester 0
  logic           req0;
  logic [c_w-1:0] inp1_0;
  logic [c_w-1:0] inp2_0;
  logic           cin_0;
  logic           ack0;
  // requester 1
  logic           req1;
  logic [c_w-1:0] inp1_1;
  logic [c_w-1:0] inp2_1;
  logic           cin_1;
  logic           ack1;
  // shared result
  logic [c_w-1:0] sum;
  logic           cout;
  logic           busy;
  // external byte adder
  logic [7:0]     add_inp1;
  logic [7:0]     add_inp2;
  logic           add_cin;
  logic [7:0]     add_sum;
  logic           add_cout;

  modport master (
    output req0, inp1_0, inp2_0, cin_0,
    output req1, inp1_1, inp2_1, cin_1,
    output add_sum, add_cout,
    input  ack0, ack1, sum, cout, busy,
    input  add_inp1, add_inp2, add_cin
  );

  modport slave (
    input  req0, inp1_0, inp2_0, cin_0,
    input  req1, inp1_1, inp2_1, cin_1,
    input  add_sum, add_cout,
    output ack0, ack1, sum, cout, busy,
    output add_inp1, add_inp2, add_cin
  );
endinterface
`default_nettype wire

// File: rtl/csa_multibyte_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : csa_multibyte_scheduler
// Brief    : Time-shares one external 8-bit carry-select adder between two
//            requesters. Each request is a BYTES-wide add performed LSB byte
//            first, one byte per cycle, with the carry chained in a register.
//            Round-robin arbitration on ties, one-cycle ack per requester.
// Revision : 1.0 - initial release
// ============================================================================
module csa_multibyte_scheduler #(
  parameter int BYTES = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  csa_multibyte_scheduler_if.slave    bus
);

  localparam int c_w  = 8 * BYTES;
  localparam int c_iw = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [c_iw-1:0] c_last = c_iw'(BYTES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADD  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_next;

  logic            r_ptr;      // last requester granted on a tie
  logic            r_win;      // requester owning the current operation
  logic [c_w-1:0]  r_a;
  logic [c_w-1:0]  r_b;
  logic            r_carry;
  logic [c_iw-1:0] r_idx;
  logic [c_w-1:0]  r_shadow;   // partial result, never visible on sum
  logic [c_w-1:0]  r_sum;
  logic            r_cout;

  logic            w_grant;
  logic            w_sel;
  logic [7:0]      w_byte_a;
  logic [7:0]      w_byte_b;
  logic [c_w-1:0]  w_shadow_nxt;

  // Pick a winner: a lone request wins outright, a tie goes to the requester not granted last
  always_comb begin
    w_grant = bus.req0 | bus.req1;
    if (bus.req0 && bus.req1) begin
      w_sel = ~r_ptr;
    end else begin
      w_sel = bus.req1;
    end
  end

  // Select the current operand bytes and merge the adder result into the shadow word
  always_comb begin
    w_byte_a     = 8'd0;
    w_byte_b     = 8'd0;
    w_shadow_nxt = r_shadow;
    for (int i = 0; i < BYTES; i++) begin
      if (r_idx == c_iw'(i)) begin
        w_byte_a                 = r_a[i*8 +: 8];
        w_byte_b                 = r_b[i*8 +: 8];
        w_shadow_nxt[i*8 +: 8]   = bus.add_sum;
      end
    end
  end

  // Next-state logic plus adder drive and ack pulses decoded from the state
  always_comb begin
    w_next       = r_state;
    bus.add_inp1 = 8'd0;
    bus.add_inp2 = 8'd0;
    bus.add_cin  = 1'b0;
    bus.ack0     = 1'b0;
    bus.ack1     = 1'b0;
    bus.busy     = (r_state != S_IDLE);
    case (r_state)
      S_IDLE: begin
        if (w_grant) begin
          w_next = S_ADD;
        end
      end
      S_ADD: begin
        bus.add_inp1 = w_byte_a;
        bus.add_inp2 = w_byte_b;
        bus.add_cin  = r_carry;
        if (r_idx == c_last) begin
          w_next = S_DONE;
        end
      end
      S_DONE: begin
        bus.ack0 = ~r_win;
        bus.ack1 = r_win;
        w_next   = S_IDLE;
      end
      default: begin
        w_next = S_IDLE;
      end
    endcase
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Operand snapshot, byte sequencing, carry chain and atomic result update
  always_ff @(posedge clk) begin
    if (rst) begin
      r_ptr    <= 1'b1;
      r_win    <= 1'b0;
      r_a      <= '0;
      r_b      <= '0;
      r_carry  <= 1'b0;
      r_idx    <= '0;
      r_shadow <= '0;
      r_sum    <= '0;
      r_cout   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_win   <= w_sel;
            if (bus.req0 && bus.req1) begin
              r_ptr <= w_sel;
            end
            r_a     <= w_sel ? bus.inp1_1 : bus.inp1_0;
            r_b     <= w_sel ? bus.inp2_1 : bus.inp2_0;
            r_carry <= w_sel ? bus.cin_1  : bus.cin_0;
            r_idx   <= '0;
          end
        end
        S_ADD: begin
          r_shadow <= w_shadow_nxt;
          r_carry  <= bus.add_cout;
          r_idx    <= r_idx + 1'b1;
          // The last byte lands straight in the result so sum/cout change in one edge
          if (r_idx == c_last) begin
            r_sum  <= w_shadow_nxt;
            r_cout <= bus.add_cout;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.sum  = r_sum;
  assign bus.cout = r_cout;

endmodule
`default_nettype wire
